// File: rtl/array_mult_pkg.sv
`default_nettype none
// ============================================================================
// Module   : array_mult_pkg
// Purpose  : Shared helpers for the pipelined array multiplier: pipeline depth,
//            configuration legality and stage-payload width.
//            The payload gains a sign-mode bit when ARRAY_MULT_SIGNED_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
package array_mult_pkg;

  // Number of pipeline stages; guards against a zero divisor on bad configs.
  function automatic int calc_lat(input int width, input int rows_per_stage);
    return width / ((rows_per_stage > 0) ? rows_per_stage : 1);
  endfunction

  // Legal when the operand is at least 2 bits and rows split evenly into stages.
  function automatic bit cfg_ok(input int width, input int rows_per_stage);
    return (width >= 2) && (rows_per_stage >= 1) && ((width % rows_per_stage) == 0);
  endfunction

  // Packed width of one stage payload: valid, [sgn], a, b, partial sum.
  function automatic int payload_width(input int width);
`ifdef ARRAY_MULT_SIGNED_EN
    return 2 + 4 * width;
`else
    return 1 + 4 * width;
`endif
  endfunction

endpackage : array_mult_pkg
`default_nettype wire

// File: rtl/array_mult_stage.sv
`default_nettype none
// ============================================================================
// Module   : array_mult_stage
// Purpose  : One pipeline stage: adds ROWS_PER_STAGE partial-product rows to the
//            carried sum and registers the payload under a shared enable.
//            With ARRAY_MULT_SIGNED_EN, signed beats sign-extend a, invert row
//            WIDTH-1 and the last stage adds the +1 correction.
// Revision : 1.0 - initial release
// ============================================================================
module array_mult_stage
  import array_mult_pkg::*;
#(
  parameter int WIDTH          = 4,
  parameter int ROWS_PER_STAGE = 1,
  parameter int STAGE          = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic [payload_width(WIDTH)-1:0]  pay_in,
  output logic [payload_width(WIDTH)-1:0]  pay_out
);

  localparam int LAT    = calc_lat(WIDTH, ROWS_PER_STAGE);
  localparam int PROD_W = 2 * WIDTH;
  localparam int ROW0   = STAGE * ROWS_PER_STAGE;

  typedef struct packed {
    logic              valid;
`ifdef ARRAY_MULT_SIGNED_EN
    logic              sgn;
`endif
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic [PROD_W-1:0] sum;
  } payload_t;

  payload_t          cur;
  payload_t          q;
  logic              sign_a;
  logic              is_sgn;
  logic [WIDTH-1:0]  bits;
  logic [PROD_W-1:0] addend;
  logic [PROD_W-1:0] row_term;
  logic [PROD_W-1:0] sum_next;

  assign cur = pay_in;

`ifdef ARRAY_MULT_SIGNED_EN
  assign is_sgn = cur.sgn;
`else
  assign is_sgn = 1'b0;
`endif
  assign sign_a = is_sgn & cur.a[WIDTH-1];

  // Row adder slice: accumulate this stage's shifted, b-gated copies of a.
  always_comb begin
    bits     = cur.b >> ROW0;
    addend   = {{WIDTH{sign_a}}, cur.a} << ROW0;
    row_term = '0;
    sum_next = cur.sum;
    for (int r = 0; r < ROWS_PER_STAGE; r++) begin
      row_term = bits[0] ? addend : '0;
      // The sign row carries negative weight: add its complement, +1 comes later.
      if (is_sgn && (ROW0 + r == WIDTH - 1)) begin
        sum_next = sum_next + ~row_term;
      end else begin
        sum_next = sum_next + row_term;
      end
      bits   = bits >> 1;
      addend = addend << 1;
    end
    if (is_sgn && (STAGE == LAT - 1)) begin
      sum_next = sum_next + {{(PROD_W-1){1'b0}}, 1'b1};
    end
  end

  // Payload register: shifts on enable; bubbles pass valid=0 but keep old data.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q.valid <= cur.valid;
      if (cur.valid) begin
`ifdef ARRAY_MULT_SIGNED_EN
        q.sgn <= cur.sgn;
`endif
        q.a   <= cur.a;
        q.b   <= cur.b;
        q.sum <= sum_next;
      end
    end
  end

  assign pay_out = q;

endmodule : array_mult_stage
`default_nettype wire

// File: rtl/pipelined_array_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_array_multiplier
// Purpose  : WIDTH x WIDTH -> 2*WIDTH pipelined array multiplier with a
//            valid/ready stream interface and a global stall.
//            Optional ARRAY_MULT_SIGNED_EN adds the sgn port (two's complement).
// Revision : 1.0 - initial release
// ============================================================================
module pipelined_array_multiplier
  import array_mult_pkg::*;
#(
  parameter int WIDTH          = 4,
  parameter int ROWS_PER_STAGE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
`ifdef ARRAY_MULT_SIGNED_EN
  input  logic                 sgn,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p
);

  localparam int LAT    = calc_lat(WIDTH, ROWS_PER_STAGE);
  localparam int PW     = payload_width(WIDTH);
  localparam int PROD_W = 2 * WIDTH;

  typedef struct packed {
    logic              valid;
`ifdef ARRAY_MULT_SIGNED_EN
    logic              sgn;
`endif
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic [PROD_W-1:0] sum;
  } payload_t;

  if (!cfg_ok(WIDTH, ROWS_PER_STAGE)) begin : g_cfg_err
    $error("pipelined_array_multiplier: WIDTH must be >= 2 and divisible by ROWS_PER_STAGE");
  end

  logic            en;
  payload_t        head;
  payload_t        tail;
  logic [PW-1:0]   chain [0:LAT];
  logic            unused_tail;

  // Whole pipe advances unless the output holds a beat the sink refuses.
  assign en       = !out_valid || out_ready;
  assign in_ready = en && !rst;

  // Pack the incoming beat; the partial sum starts at zero.
  always_comb begin
    head       = '0;
    head.valid = in_valid && in_ready;
`ifdef ARRAY_MULT_SIGNED_EN
    head.sgn   = sgn;
`endif
    head.a     = a;
    head.b     = b;
  end

  assign chain[0] = head;

  for (genvar s = 0; s < LAT; s++) begin : g_stage
    array_mult_stage #(
      .WIDTH          (WIDTH),
      .ROWS_PER_STAGE (ROWS_PER_STAGE),
      .STAGE          (s)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .pay_in  (chain[s]),
      .pay_out (chain[s+1])
    );
  end

  // The last stage register drives the outputs directly.
  assign tail      = chain[LAT];
  assign out_valid = tail.valid;
  assign p         = tail.sum;

`ifdef ARRAY_MULT_SIGNED_EN
  assign unused_tail = ^{tail.a, tail.b, tail.sgn};
`else
  assign unused_tail = ^{tail.a, tail.b};
`endif

endmodule : pipelined_array_multiplier
`default_nettype wire

// File: tb/tb_pipelined_array_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_array_multiplier
// Purpose  : Self-checking bench: cycle model of the stream behaviour for the
//            default configuration plus directed literal checks, and a small
//            directed test of the WIDTH=8 / ROWS_PER_STAGE=2 configuration.
//            Signed vectors are exercised when ARRAY_MULT_SIGNED_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipelined_array_multiplier;

  localparam int LAT = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b1;
  logic       out_ready = 1'b1;
  logic [3:0] a = 4'd5;
  logic [3:0] b = 4'd3;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] p;
`ifdef ARRAY_MULT_SIGNED_EN
  logic       sgn = 1'b0;
`endif

  logic        wv = 1'b0;
  logic [7:0]  wa = 8'd0;
  logic [7:0]  wb = 8'd0;
  logic        w_in_ready;
  logic        w_out_valid;
  logic [15:0] wp;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  pipelined_array_multiplier #(.WIDTH(4), .ROWS_PER_STAGE(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
`ifdef ARRAY_MULT_SIGNED_EN
    .sgn       (sgn),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p)
  );

  pipelined_array_multiplier #(.WIDTH(8), .ROWS_PER_STAGE(2)) dut_wide (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (wv),
    .in_ready  (w_in_ready),
    .a         (wa),
    .b         (wb),
`ifdef ARRAY_MULT_SIGNED_EN
    .sgn       (1'b0),
`endif
    .out_valid (w_out_valid),
    .out_ready (1'b1),
    .p         (wp)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference product from plain integer arithmetic.
  function automatic logic [7:0] ref_mul(input logic [3:0] x, input logic [3:0] y, input bit s);
    int xi;
    int yi;
    xi = s ? int'($signed(x)) : int'(x);
    yi = s ? int'($signed(y)) : int'(y);
    return 8'(xi * yi);
  endfunction

  // ---------------- stream model: beats age one step per enabled edge ----------
  typedef struct {
    logic [7:0] prod;
    int         age;
  } ent_t;

  ent_t       mq[$];
  logic [7:0] last_p = 8'd0;

  always @(negedge clk) begin
    bit exp_ov;
    bit en;
    bit cur_sgn;
`ifdef ARRAY_MULT_SIGNED_EN
    cur_sgn = sgn;
`else
    cur_sgn = 1'b0;
`endif
    exp_ov = (mq.size() > 0) && (mq[0].age == LAT);
    check("model_out_valid", out_valid, exp_ov);
    if (exp_ov) check("model_p", p, mq[0].prod);
    else        check("model_p_hold", p, last_p);
    en = !exp_ov || out_ready;
    check("model_in_ready", in_ready, en && !rst);
    if (rst) begin
      mq.delete();
      last_p = 8'd0;
    end else if (en) begin
      if (exp_ov) void'(mq.pop_front());
      foreach (mq[i]) mq[i].age++;
      if (in_valid) mq.push_back('{prod: ref_mul(a, b, cur_sgn), age: 1});
      if (mq.size() > 0 && mq[0].age == LAT) last_p = mq[0].prod;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    // Reset with in_valid held high: nothing accepted, outputs cleared.
    step();
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_p", p, 0);
    check("rst_in_ready", in_ready, 0);
    step();
    @(negedge clk);
    check("rst_in_ready2", in_ready, 0);
    check("rst_w_p", wp, 0);
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    step();

    // Wide configuration: 255*255 then 128*2, latency 4.
    for (int k = 0; k < 6; k++) begin
      if (k == 0) begin wv = 1'b1; wa = 8'd255; wb = 8'd255; end
      else if (k == 1) begin wa = 8'd128; wb = 8'd2; end
      else wv = 1'b0;
      @(negedge clk);
      if (k == 3) check("wide_not_early", w_out_valid, 0);
      if (k == 4) begin
        check("wide_valid0", w_out_valid, 1);
        check("wide_p0", wp, 65025);
      end
      if (k == 5) begin
        check("wide_valid1", w_out_valid, 1);
        check("wide_p1", wp, 256);
      end
      step();
    end

    // Squares sweep: one beat per cycle in, one result per cycle out.
    for (int k = 0; k < 20; k++) begin
      if (k < 16) begin in_valid = 1'b1; a = 4'(k); b = 4'(k); end
      else in_valid = 1'b0;
      @(negedge clk);
      if (k == 3) check("sq_not_early", out_valid, 0);
      if (k >= 4) begin
        check("sq_valid", out_valid, 1);
        check("sq_p", p, 32'((k - 4) * (k - 4)));
      end
      step();
    end
    check("sq_last_225", p, 32'hE1);

    // Back-pressure: freeze six cycles from the first out_valid.
    for (int k = 0; k < 17; k++) begin
      case (k)
        0: begin in_valid = 1'b1; a = 4'd3;  b = 4'd5;  end
        1: begin a = 4'd7;  b = 4'd9;  end
        2: begin a = 4'd15; b = 4'd14; end
        3: in_valid = 1'b0;
        4, 5, 6, 7, 8, 9: begin out_ready = 1'b0; in_valid = 1'b1; a = 4'd2; b = 4'd2; end
        10: out_ready = 1'b1;
        default: in_valid = 1'b0;
      endcase
      @(negedge clk);
      if (k >= 4 && k <= 9) begin
        check("bp_hold_p", p, 15);
        check("bp_hold_valid", out_valid, 1);
        check("bp_in_ready", in_ready, 0);
      end
      if (k == 10) check("bp_rel_p0", p, 15);
      if (k == 11) check("bp_rel_p1", p, 63);
      if (k == 12) check("bp_rel_p2", p, 210);
      step();
    end

    // Reset with three beats in flight; a fresh beat follows.
    for (int k = 0; k < 12; k++) begin
      case (k)
        0: begin in_valid = 1'b1; a = 4'd6;  b = 4'd7;  end
        1: begin a = 4'd9;  b = 4'd9;  end
        2: begin a = 4'd11; b = 4'd13; end
        3: begin in_valid = 1'b0; rst = 1'b1; end
        4: begin rst = 1'b0; in_valid = 1'b1; a = 4'd12; b = 4'd11; end
        default: in_valid = 1'b0;
      endcase
      @(negedge clk);
      if (k == 8) begin
        check("mid_rst_valid", out_valid, 1);
        check("mid_rst_p", p, 132);
      end else if (k >= 3) begin
        check("mid_rst_no_beat", out_valid, 0);
      end
      step();
    end

`ifdef ARRAY_MULT_SIGNED_EN
    begin
      logic [3:0] sa [5] = '{4'h8, 4'h8, 4'hF, 4'h8, 4'hF};
      logic [3:0] sb [5] = '{4'h8, 4'h7, 4'h1, 4'h8, 4'hF};
      logic       ss [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      logic [7:0] se [5] = '{8'h40, 8'hC8, 8'hFF, 8'h40, 8'hE1};
      for (int k = 0; k < 9; k++) begin
        if (k < 5) begin in_valid = 1'b1; a = sa[k]; b = sb[k]; sgn = ss[k]; end
        else in_valid = 1'b0;
        @(negedge clk);
        if (k >= 4) check("signed_p", p, se[k-4]);
        step();
      end
    end
`endif

    repeat (6) step();
    check("drain_empty", mq.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule : tb_pipelined_array_multiplier
`default_nettype wire
